subpel_line_interpolator: RTL
=============================

Name: subpel_line_interpolator

Overview:
- Streaming, parametrised successor to the combinational A/B/C sub-pixel filters.
- Accepts one pixel per cycle of a raster line through a valid/ready handshake and keeps an 8-entry sliding window.
- Pads both line edges by replicating the edge pixel.
- Emits one registered output per input pixel, carrying all three fractional phases (A = quarter, B = half, C = three-quarter). Sits between the line reader and the motion-compensation accumulator.

Parameters:
- PIXEL_W, 8, input pixel width (unsigned).
- ACC_W, PIXEL_W+8, localparam; signed raw filter-sum width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_L  in  1  synchronous, active-low reset.
- in_valid  in  1  pixel offered.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_pixel  in  PIXEL_W  unsigned pixel.
- in_last  in  1  marks the final pixel of a line.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_a / out_b / out_c  out  OUT_W each  phase results. OUT_W = ACC_W signed, or PIXEL_W unsigned with ROUND_CLIP_EN.
- out_last  out  1  final output of a line.

Behaviour:
Window:
- w[7:0] holds PIXEL_W-wide entries. A shift does w[i] <= w[i-1] for i=7..1, and w[0] <= the new sample.
- Output n is computed with w[4]=p[n], w[3]=p[n+1], w[2]=p[n+2], w[1]=p[n+3], w[5]=p[n-1], w[6]=p[n-2].

Filters, on the post-shift window, signed ACC_W:
- A = 4w6 - 10w5 + 58w4 + 17w3 - 5w2
- B = 4w6 - 11w5 + 40w4 + 40w3 - 11w2 + 4w1
- C = -5w6 + 17w5 + 58w4 - 10w3 + 4w2

Slot and shift counter:
- slot_free = !out_valid || out_ready.
- Shift counter sh is 3 bits and saturates at 4.

State machine:
- IDLE: in_ready=1. An accepted pixel loads all 8 entries with it and sets sh=0. If in_last → FLUSH, else → RUN. No output.
- RUN: in_ready=slot_free. An accepted pixel shifts in and sets sh=min(sh+1,4). If sh reaches 4, the output register loads. If in_last → FLUSH.
- FLUSH: in_ready=0. Each cycle with slot_free, shift in a copy of w[0] (pad), increment the pad counter 0..3, and load an output if sh reaches 4. On the 4th pad, set out_last=1 and → IDLE.

Output count and ordering:
- A line of L ≥ 1 pixels gives exactly L outputs, in order, with out_last only on the L-th.

Output register:
- Loads the cycle of the shift, so out_valid rises one cycle after the shift edge (latency 1 cycle).
- A word is held stable while out_valid && !out_ready.
- Load and drain in the same cycle is allowed (full throughput).

Reset (reset_L=0 at a clock edge):
- state=IDLE, w=0, sh=0, pad counter=0.
- out_valid=0, out_last=0, out_a/b/c=0.
- in_ready is forced 0 while reset_L=0.
- Reset mid-line or mid-FLUSH discards all partial state and pending output.

Arithmetic:
- Coefficients and pixels are zero-extended to ACC_W before multiply; no overflow is possible (max |sum| < 2^(PIXEL_W+7)).
- B gain is 66 (approximate filter); it is not normalised.

Optional Feature:
ROUND_CLIP_EN
- Defined: OUT_W=PIXEL_W. Each phase = clamp((sum + 32) >>> 6, 0, 2^PIXEL_W - 1). The arithmetic shift floors.
- Undefined: OUT_W=ACC_W, with the raw signed sum output.
- Handshake and timing are identical in both builds.

Test Plan:
- Flat line: L=8, all pixels 100, out_ready=1 → 8 outputs of a=6400, b=6600, c=6400; out_last on the 8th; in_ready never drops in RUN.
- Impulse: L=9, p[4]=64, others 0 → A at n=2..6 = -320, 1088, 3712, -640, 256; B at n=1 = 256 and n=4 = 2560; C at n=3 = -640 and n=4 = 3712; all other entries follow the formulas.
- Single pixel: L=1, pixel 200 → IDLE→FLUSH, then 4 pad cycles with in_ready=0. One output a=12800, b=13200, c=12800, out_last=1, then back to IDLE.
- Backpressure: out_ready=0 for 5 cycles mid-line → in_ready=0 and out_a/b/c/out_last held stable. On release, the next outputs follow with no loss or duplication, then full rate.
- Reset during FLUSH: reset_L=0 for 1 cycle → next cycle out_valid=0, in_ready=1. A following flat line of 50s gives exactly L outputs of a=3200.
- ROUND_CLIP_EN: flat 255 → b=(16830+32)>>>6=263, clamped to 255, and a=c=255. Impulse 255 at w2 → A=-1275, giving -20, clamped to 0.

Source files
------------

// File: rtl/subpel_line_interpolator.sv
// Streaming quarter/half/three-quarter sub-pixel line interpolator with edge replication.
// Latency: one cycle from the window shift to out_valid; one output per input pixel.
// Backpressure: in_ready drops while an unread output is held; the flush stalls until the output slot frees.
// Optional build macro ROUND_CLIP_EN: outputs rounded (+32, >>>6) and clamped to PIXEL_W unsigned.
module subpel_line_interpolator #(
    parameter  int PIXEL_W = 8,
    localparam int ACC_W   = PIXEL_W + 8,
`ifdef ROUND_CLIP_EN
    localparam int OUT_W   = PIXEL_W
`else
    localparam int OUT_W   = ACC_W
`endif
) (
    input  logic               clock,
    input  logic               reset_L,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_a,
    output logic [OUT_W-1:0]   out_b,
    output logic [OUT_W-1:0]   out_c,
    output logic               out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Filter coefficients, all carried as positive magnitudes; signs live in the sums.
    localparam logic signed [ACC_W-1:0] K4  = ACC_W'(4);
    localparam logic signed [ACC_W-1:0] K5  = ACC_W'(5);
    localparam logic signed [ACC_W-1:0] K10 = ACC_W'(10);
    localparam logic signed [ACC_W-1:0] K11 = ACC_W'(11);
    localparam logic signed [ACC_W-1:0] K17 = ACC_W'(17);
    localparam logic signed [ACC_W-1:0] K40 = ACC_W'(40);
    localparam logic signed [ACC_W-1:0] K58 = ACC_W'(58);
`ifdef ROUND_CLIP_EN
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(32);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << PIXEL_W) - 1);
`endif

    // Zero-extend an unsigned pixel into the signed accumulator domain.
    function automatic logic signed [ACC_W-1:0] ext(input logic [PIXEL_W-1:0] p);
        return $signed({8'd0, p});
    endfunction

    // Turn a raw filter sum into the output word for this build.
    function automatic logic [OUT_W-1:0] fin(input logic signed [ACC_W-1:0] s);
`ifdef ROUND_CLIP_EN
        logic signed [ACC_W-1:0] r;
        r = (s + RND) >>> 6;
        if (r[ACC_W-1])
            return '0;
        else if (r > MAXV)
            return '1;
        else
            return r[PIXEL_W-1:0];
`else
        return s;
`endif
    endfunction

    // Window taps w[0..6]; w[7] feeds no filter tap, so it is not stored.
    state_t                    state_q, state_d;
    logic [6:0][PIXEL_W-1:0]   w_q, w_d;
    logic [2:0]                sh_q, sh_d, sh_inc;
    logic [1:0]                pad_q, pad_d;
    logic                      slot_free, ready_c, load, last_d;
    logic signed [ACC_W-1:0]   sum_a, sum_b, sum_c;

    assign slot_free = !out_valid || out_ready;
    assign sh_inc    = (sh_q == 3'd4) ? 3'd4 : sh_q + 3'd1;
    assign in_ready  = reset_L && ready_c;

    // Next-state, window update and output-load decision.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        sh_d    = sh_q;
        pad_d   = pad_q;
        ready_c = 1'b0;
        load    = 1'b0;
        last_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    // First pixel replicates across the window: left-edge padding.
                    w_d     = {7{in_pixel}};
                    sh_d    = 3'd0;
                    pad_d   = 2'd0;
                    state_d = in_last ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                ready_c = slot_free;
                if (in_valid && slot_free) begin
                    w_d  = {w_q[5:0], in_pixel};
                    sh_d = sh_inc;
                    load = (sh_inc == 3'd4);
                    if (in_last)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    // Right-edge padding: re-insert the newest pixel four times.
                    w_d   = {w_q[5:0], w_q[0]};
                    sh_d  = sh_inc;
                    pad_d = pad_q + 2'd1;
                    load  = (sh_inc == 3'd4);
                    if (pad_q == 2'd3) begin
                        last_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Three phase filters evaluated on the post-shift window.
    always_comb begin
        sum_a = K4 * ext(w_d[6]) - K10 * ext(w_d[5]) + K58 * ext(w_d[4])
              + K17 * ext(w_d[3]) - K5 * ext(w_d[2]);
        sum_b = K4 * ext(w_d[6]) - K11 * ext(w_d[5]) + K40 * ext(w_d[4])
              + K40 * ext(w_d[3]) - K11 * ext(w_d[2]) + K4 * ext(w_d[1]);
        sum_c = K17 * ext(w_d[5]) - K5 * ext(w_d[6]) + K58 * ext(w_d[4])
              - K10 * ext(w_d[3]) + K4 * ext(w_d[2]);
    end

    // Control state and window registers.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            sh_q    <= 3'd0;
            pad_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            sh_q    <= sh_d;
            pad_q   <= pad_d;
        end
    end

    // Output register: load on a producing shift, drop valid on drain, else hold.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_last  <= last_d;
            out_a     <= fin(sum_a);
            out_b     <= fin(sum_b);
            out_c     <= fin(sum_c);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
